axis2hs: RTL and testbench

AXIS2HS -- requirements
Module: axis2hs

---
 rtl/axis2hs_pkg.sv | 15 +
 rtl/axis2hs_skid.sv | 39 +++
 rtl/axis2hs.sv | 102 ++++++++++
 tb/tb_axis2hs.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis2hs_pkg.sv
// Shared pool-stream definitions: FSM state encoding and default widths
// used by axis2hs and hs2axis.
package axis2hs_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LEN_W  = 16;
  localparam int unsigned SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ps_state_t;

endpackage

// File: rtl/axis2hs_skid.sv
// Two-entry skid buffer between the AXIS slave and the FIFO write port.
// The caller guarantees no push when full and no pop when empty.
module axis2hs_skid
  import axis2hs_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/axis2hs.sv
// AXI4-Stream slave to ap_ctrl_hs FIFO writer: moves one frame of
// frame_len words per ap_start, flagging TLAST disagreements.
module axis2hs
  import axis2hs_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] in_TDATA,
  input  logic              in_TVALID,
  input  logic              in_TLAST,
  output logic              in_TREADY,
  output logic [DATA_W-1:0] out_V_V_din,
  output logic              out_V_V_write,
  input  logic              out_V_V_full_n,
  output logic [1:0]        tlast_err
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  ps_state_t        state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             tready_q;
  logic [1:0]       fill, fill_nxt;
  logic             accept, wr, last_by_count, frame_end;

  assign accept        = in_TVALID && tready_q;
  assign wr            = (fill != 2'd0) && out_V_V_full_n;
  // cnt_q stops at len_q, so the compare never needs an extra bit
  assign last_by_count = (cnt_q == (len_q - LEN_ONE));
  assign frame_end     = accept && (in_TLAST || last_by_count);
  assign fill_nxt      = fill + {1'b0, accept} - {1'b0, wr};

  axis2hs_skid #(.DATA_W(DATA_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (in_TDATA),
    .pop       (wr),
    .head      (out_V_V_din),
    .count     (fill)
  );

  always_comb begin
    state_nxt = state;
    ap_done   = 1'b0;
    ap_ready  = 1'b0;
    ap_idle   = 1'b0;
    unique case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_nxt = RUN;
      end
      RUN: begin
        if (frame_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fill_nxt == 2'd0) begin
          state_nxt = IDLE;
          ap_done   = 1'b1;
          ap_ready  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      tready_q  <= 1'b0;
      tlast_err <= '0;
    end else begin
      state <= state_nxt;
      // Registered ready looks ahead at next occupancy so a push never overflows
      tready_q <= (state_nxt == RUN) && (fill_nxt < 2'd2);
      if (state == IDLE && ap_start) begin
        len_q     <= (frame_len == '0) ? LEN_ONE : frame_len;
        cnt_q     <= '0;
        tlast_err <= '0;
      end else if (state == RUN && accept) begin
        cnt_q <= cnt_q + LEN_ONE;
        if (in_TLAST && !last_by_count) tlast_err[0] <= 1'b1;
        if (!in_TLAST && last_by_count) tlast_err[1] <= 1'b1;
      end
    end
  end

  assign in_TREADY     = tready_q;
  assign out_V_V_write = wr;

endmodule

// File: tb/tb_axis2hs.sv
// Self-checking bench for axis2hs: directed frames, an occupancy/order
// model of the stream, and per-frame literal expectations.
module tb_axis2hs;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, ap_ready;
  logic [LW-1:0] frame_len = '0;
  logic [DW-1:0] in_TDATA = '0;
  logic          in_TVALID = 1'b0;
  logic          in_TLAST = 1'b0;
  logic          in_TREADY;
  logic [DW-1:0] out_V_V_din;
  logic          out_V_V_write;
  logic          out_V_V_full_n = 1'b1;
  logic [1:0]    tlast_err;

  axis2hs #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clock          (clock),
    .reset          (reset),
    .ap_start       (ap_start),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ap_ready       (ap_ready),
    .frame_len      (frame_len),
    .in_TDATA       (in_TDATA),
    .in_TVALID      (in_TVALID),
    .in_TLAST       (in_TLAST),
    .in_TREADY      (in_TREADY),
    .out_V_V_din    (out_V_V_din),
    .out_V_V_write  (out_V_V_write),
    .out_V_V_full_n (out_V_V_full_n),
    .tlast_err      (tlast_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0, acc_total = 0, wr_total = 0, done_total = 0;
  int first_acc = -1, first_wr = -1, last_wr = -1, done_first = -1, done_last = -1;
  int acc_base = 0, done_base = 0, start_cyc = 0;
  bit src_on = 0, src_tlast_all = 0, full_on = 0, saw_occ2 = 0;
  int src_n = 0, src_tlast_pos = 0, full_lo = 0, full_hi = 0;
  logic [DW-1:0] src_base = '0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Event monitor: handshakes, writes and done pulses seen at each rising edge
  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      acc_total = 0;
      wr_total  = 0;
    end else begin
      if (in_TVALID && in_TREADY) begin
        if (first_acc < 0) first_acc = cyc;
        acc_total++;
      end
      if (out_V_V_write) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        wr_total++;
      end
      if (ap_done) begin
        if (done_first < 0) done_first = cyc;
        done_last = cyc;
        done_total++;
      end
    end
  end

  // Source and FIFO back-pressure driver
  always @(negedge clock) begin
    int idx;
    int rel;
    #2;
    idx = acc_total - acc_base;
    if (src_on && idx >= 0 && idx < src_n) begin
      in_TVALID = 1'b1;
      in_TDATA  = src_base + DW'(idx);
      in_TLAST  = src_tlast_all || (idx + 1 == src_tlast_pos);
    end else begin
      in_TVALID = 1'b0;
      in_TDATA  = '0;
      in_TLAST  = 1'b0;
    end
    rel = cyc - start_cyc;
    out_V_V_full_n = !(full_on && rel >= full_lo && rel <= full_hi);
  end

  // Compare process: occupancy = accepted - written must drive the write port
  always @(negedge clock) begin
    int occ;
    if (!reset) begin
      check("reset_write", out_V_V_write, 0);
      check("reset_idle", ap_idle, 1);
      check("reset_tready", in_TREADY, 0);
      check("reset_done", ap_done, 0);
      check("reset_err", tlast_err, 0);
      check("reset_din", out_V_V_din, 0);
    end else begin
      occ = acc_total - wr_total;
      check("write_rule", out_V_V_write, (occ > 0) && out_V_V_full_n);
      if (out_V_V_write) begin
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else check("write_data", out_V_V_din, exp_q.pop_front());
      end
      check("ready_eq_done", ap_ready, ap_done);
      if (occ >= 2) begin
        saw_occ2 = 1;
        check("tready_full", in_TREADY, 0);
      end
      if (ap_idle) check("tready_idle", in_TREADY, 0);
    end
  end

  task automatic run_frame(input string tag, input int len, input int nbeats, input int tlast_pos,
                           input bit tlast_all, input bit full_en, input int lo, input int hi,
                           input bit hold, input int nframes, input logic [DW-1:0] base);
    int len_eff, k, budget;
    logic [1:0] exp_err;
    len_eff = (len == 0) ? 1 : len;
    k = (tlast_pos > 0 && tlast_pos <= len_eff) ? tlast_pos : len_eff;
    exp_err[0] = (tlast_pos > 0 && tlast_pos < len_eff);
    exp_err[1] = !(tlast_pos > 0 && tlast_pos <= len_eff);
    @(negedge clock);
    #1;
    exp_q.delete();
    for (int i = 0; i < k * nframes; i++) exp_q.push_back(base + DW'(i));
    acc_base = acc_total; done_base = done_total;
    first_acc = -1; first_wr = -1; last_wr = -1; done_first = -1; done_last = -1;
    saw_occ2 = 0;
    src_base = base; src_n = nbeats; src_tlast_pos = tlast_pos; src_tlast_all = tlast_all;
    full_on = full_en; full_lo = lo; full_hi = hi;
    frame_len = LW'(len);
    start_cyc = cyc;
    src_on = 1;
    ap_start = 1'b1;
    if (!hold) begin
      @(negedge clock);
      #1;
      ap_start = 1'b0;
    end
    budget = 0;
    while (done_total - done_base < nframes && budget < 300) begin
      @(negedge clock);
      budget++;
    end
    #1;
    ap_start = 1'b0;
    check({tag, "_no_timeout"}, budget < 300, 1);
    repeat (4) @(negedge clock);
    #1;
    check({tag, "_accepted"}, acc_total - acc_base, k * nframes);
    check({tag, "_pending_words"}, exp_q.size(), 0);
    check({tag, "_done_pulses"}, done_total - done_base, nframes);
    check({tag, "_tlast_err"}, tlast_err, exp_err);
    check({tag, "_idle"}, ap_idle, 1);
    src_on = 0;
    full_on = 0;
    exp_q.delete();
  endtask

  initial begin
    int budget;
    repeat (3) @(negedge clock);
    check("init_idle", ap_idle, 1);
    check("init_tready", in_TREADY, 0);
    check("init_write", out_V_V_write, 0);
    check("init_err", tlast_err, 2'b00);
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);

    run_frame("f4", 4, 4, 4, 0, 0, 0, 0, 0, 1, 32'h0000_0100);
    check("f4_latency", first_wr - first_acc, 1);
    check("f4_back_to_back_writes", last_wr - first_wr, 3);

    run_frame("f8_stall", 8, 8, 8, 0, 1, 3, 7, 0, 1, 32'h0000_0000);
    check("f8_two_held", saw_occ2, 1);

    run_frame("f5_early", 5, 5, 3, 0, 0, 0, 0, 0, 1, 32'h0000_0200);
    check("f5_err_literal", tlast_err, 2'b01);

    run_frame("f3_nolast", 3, 4, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0300);
    check("f3_err_literal", tlast_err, 2'b10);

    // Reset after two of six words
    @(negedge clock);
    #1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h0000_0400 + DW'(i));
    acc_base = acc_total;
    src_base = 32'h0000_0400; src_n = 6; src_tlast_pos = 6; src_tlast_all = 0;
    frame_len = LW'(6);
    start_cyc = cyc;
    src_on = 1;
    ap_start = 1'b1;
    @(negedge clock);
    #1;
    ap_start = 1'b0;
    budget = 0;
    while (acc_total - acc_base < 2 && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    check("rst_mid_reached", budget < 50, 1);
    #1;
    reset = 1'b0;
    src_on = 0;
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clock);
    check("rst_mid_no_writes", wr_total, 0);
    check("rst_mid_idle", ap_idle, 1);
    check("rst_mid_err", tlast_err, 2'b00);

    run_frame("f2_after_rst", 2, 2, 2, 0, 0, 0, 0, 0, 1, 32'h0000_0500);

    run_frame("b2b", 1, 2, 1, 1, 0, 0, 0, 1, 2, 32'h0000_0600);
    check("b2b_done_spacing", done_last - done_first, 3);

    run_frame("len0", 0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0700);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
